// File: rtl/alu_homework_pkg.sv
// ============================================================================
// Module      : alu_homework_pkg
// Description : Shared constants for alu_homework: OP class codes, data-proc
//               command codes and flag bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_homework_pkg;

    localparam logic [1:0] OP_DP  = 2'd0;
    localparam logic [1:0] OP_MEM = 2'd1;
    localparam logic [1:0] OP_BR  = 2'd2;
    localparam logic [1:0] OP_MUL = 2'd3;

    localparam logic [3:0] CMD_AND = 4'd0;
    localparam logic [3:0] CMD_EOR = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_RSB = 4'd3;
    localparam logic [3:0] CMD_ADD = 4'd4;
    localparam logic [3:0] CMD_ADC = 4'd5;
    localparam logic [3:0] CMD_SBC = 4'd6;
    localparam logic [3:0] CMD_RSC = 4'd7;
    localparam logic [3:0] CMD_TST = 4'd8;
    localparam logic [3:0] CMD_TEQ = 4'd9;
    localparam logic [3:0] CMD_CMP = 4'd10;
    localparam logic [3:0] CMD_CMN = 4'd11;
    localparam logic [3:0] CMD_ORR = 4'd12;
    localparam logic [3:0] CMD_MOV = 4'd13;
    localparam logic [3:0] CMD_BIC = 4'd14;
    localparam logic [3:0] CMD_MVN = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

`default_nettype wire

// File: rtl/alu_homework_addsub_core.sv
// ============================================================================
// Module      : alu_homework_addsub_core
// Description : Combinational adder shared by all add/subtract paths;
//               subtraction is a + ~b + cin, so carry-out is NOT borrow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_addsub_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_invert_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_full;

    assign w_b_eff    = i_invert_b ? ~i_b : i_b;
    assign w_full     = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_cin};
    assign o_sum      = w_full[WIDTH-1:0];
    assign o_carry    = w_full[WIDTH];
    // Signed overflow: both addends share a sign that the sum does not.
    assign o_overflow = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                        (w_full[WIDTH-1] != i_a[WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/alu_homework.sv
// ============================================================================
// Module      : alu_homework
// Description : Registered 32-bit ARM-style ALU with NZCV flags. Define
//               ALU_MUL_EN to enable the OP=3 unsigned multiply.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_homework
    import alu_homework_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] port_A,
    input  logic [WIDTH-1:0] port_B,
    input  logic [3:0]       cmd,
    input  logic [1:0]       OP,
    output logic [WIDTH-1:0] ALU_output,
    output logic [3:0]       ALU_Flags
);

    logic [WIDTH-1:0] r_result_q, w_result_d;
    logic [3:0]       r_flags_q, w_flags_d;

    logic [WIDTH-1:0] w_core_a, w_core_b, w_core_sum;
    logic             w_core_cin, w_core_inv, w_core_carry, w_core_ovf;
    logic             w_arith;
    logic             w_cin;

    assign w_cin = r_flags_q[FLAG_C];

    alu_addsub_core #(.WIDTH(WIDTH)) u_addsub (
        .i_a        (w_core_a),
        .i_b        (w_core_b),
        .i_cin      (w_core_cin),
        .i_invert_b (w_core_inv),
        .o_sum      (w_core_sum),
        .o_carry    (w_core_carry),
        .o_overflow (w_core_ovf)
    );

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] w_product;
    assign w_product = port_A * port_B;
`endif

    always_comb begin
        w_core_a   = port_A;
        w_core_b   = port_B;
        w_core_cin = 1'b0;
        w_core_inv = 1'b0;
        w_arith    = 1'b0;
        w_result_d = '0;

        case (OP)
            OP_DP: begin
                case (cmd)
                    CMD_AND, CMD_TST: w_result_d = port_A & port_B;
                    CMD_EOR, CMD_TEQ: w_result_d = port_A ^ port_B;
                    CMD_ORR:          w_result_d = port_A | port_B;
                    CMD_MOV:          w_result_d = port_B;
                    CMD_BIC:          w_result_d = port_A & ~port_B;
                    CMD_MVN:          w_result_d = ~port_B;
                    CMD_SUB, CMD_CMP: begin
                        w_arith    = 1'b1;
                        w_core_inv = 1'b1;
                        w_core_cin = 1'b1;
                        w_result_d = w_core_sum;
                    end
                    CMD_RSB: begin
                        w_arith    = 1'b1;
                        w_core_a   = port_B;
                        w_core_b   = port_A;
                        w_core_inv = 1'b1;
                        w_core_cin = 1'b1;
                        w_result_d = w_core_sum;
                    end
                    CMD_SBC: begin
                        w_arith    = 1'b1;
                        w_core_inv = 1'b1;
                        w_core_cin = w_cin;
                        w_result_d = w_core_sum;
                    end
                    CMD_RSC: begin
                        w_arith    = 1'b1;
                        w_core_a   = port_B;
                        w_core_b   = port_A;
                        w_core_inv = 1'b1;
                        w_core_cin = w_cin;
                        w_result_d = w_core_sum;
                    end
                    CMD_ADC: begin
                        w_arith    = 1'b1;
                        w_core_cin = w_cin;
                        w_result_d = w_core_sum;
                    end
                    default: begin
                        // ADD and CMN
                        w_arith    = 1'b1;
                        w_result_d = w_core_sum;
                    end
                endcase
            end
            OP_MEM: begin
                // cmd[3] is the U bit: up adds the offset, down subtracts it.
                w_arith    = 1'b1;
                w_core_inv = ~cmd[3];
                w_core_cin = ~cmd[3];
                w_result_d = w_core_sum;
            end
            OP_BR: begin
                w_arith    = 1'b1;
                w_result_d = w_core_sum;
            end
            default: begin
`ifdef ALU_MUL_EN
                w_result_d = w_product;
`else
                w_result_d = '0;
`endif
            end
        endcase

        w_flags_d         = 4'b0000;
        w_flags_d[FLAG_N] = w_result_d[WIDTH-1];
        w_flags_d[FLAG_Z] = (w_result_d == '0);
        w_flags_d[FLAG_C] = w_arith & w_core_carry;
        w_flags_d[FLAG_V] = w_arith & w_core_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_q <= '0;
            r_flags_q  <= 4'b0000;
        end else begin
            r_result_q <= w_result_d;
            r_flags_q  <= w_flags_d;
        end
    end

    assign ALU_output = r_result_q;
    assign ALU_Flags  = r_flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_homework.sv
// ============================================================================
// Module      : tb_alu_homework
// Description : Directed scoreboard bench for alu_homework.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_homework;

    logic        clk;
    logic        rst_n;
    logic [31:0] port_A;
    logic [31:0] port_B;
    logic [3:0]  cmd;
    logic [1:0]  OP;
    logic [31:0] ALU_output;
    logic [3:0]  ALU_Flags;

    int total;
    int bad;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb[$];

    alu_homework #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .port_A     (port_A),
        .port_B     (port_B),
        .cmd        (cmd),
        .OP         (OP),
        .ALU_output (ALU_output),
        .ALU_Flags  (ALU_Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Drive one operation at the falling edge, record the expectation, and
    // compare it just after the rising edge that registers it.
    task automatic step(input string tag, input logic [1:0] op, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        OP = op; cmd = c; port_A = a; port_B = b;
        e.tag = tag; e.res = er; e.flg = ef;
        sb.push_back(e);
        @(posedge clk);
        #1;
        // Inputs wiggling after the edge must not disturb the registered value.
        port_A = ~port_A;
        port_B = port_B + 32'd3;
        #1;
        e = sb.pop_front();
        check_val({e.tag, "_res"}, ALU_output, e.res);
        check_val({e.tag, "_flg"}, {28'd0, ALU_Flags}, {28'd0, e.flg});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        OP = 2'd0; cmd = 4'd4; port_A = 32'h1234_5678; port_B = 32'h0000_0FFF;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_res", ALU_output, 32'd0);
        check_val("reset_flg", {28'd0, ALU_Flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step("eor",  2'd0, 4'd1,  32'h0001_1111, 32'h1, 32'h0001_1110, 4'b0000);
        step("sub",  2'd0, 4'd2,  32'h0001_1111, 32'h1, 32'h0001_1110, 4'b0010);
        step("rsb",  2'd0, 4'd3,  32'h0001_1111, 32'h1, 32'hFFFE_EEF0, 4'b1000);
        step("add",  2'd0, 4'd4,  32'h0001_1111, 32'h1, 32'h0001_1112, 4'b0000);
        step("cmp",  2'd0, 4'd10, 32'h0001_1111, 32'h1, 32'h0001_1110, 4'b0010);
        step("orr",  2'd0, 4'd12, 32'h0001_1111, 32'h1, 32'h0001_1111, 4'b0000);
        step("and",  2'd0, 4'd0,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000);
        step("bic",  2'd0, 4'd14, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_00F0, 4'b0000);
        step("mvn",  2'd0, 4'd15, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 4'b1000);
        step("mov",  2'd0, 4'd13, 32'h1234_5678, 32'h0, 32'h0, 4'b0100);
        step("teq",  2'd0, 4'd9,  32'h5, 32'h5, 32'h0, 4'b0100);
        step("cmpv", 2'd0, 4'd10, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0011);

        step("mem_dn", 2'd1, 4'd0, 32'd15, 32'd14, 32'd1,  4'b0010);
        step("mem_up", 2'd1, 4'd8, 32'd15, 32'd14, 32'd29, 4'b0000);
        step("mem_up_x", 2'd1, 4'hF, 32'd1, 32'd2, 32'd3,  4'b0000);
        step("mem_dn_x", 2'd1, 4'h7, 32'd1, 32'd2, 32'hFFFF_FFFF, 4'b1000);
        step("br_wrap", 2'd2, 4'd4, 32'hFFFF_FFFF, 32'd20, 32'h13, 4'b0010);
        step("br_ign",  2'd2, 4'd2, 32'd8, 32'd8, 32'd16, 4'b0000);

        step("add_ov",  2'd0, 4'd4, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001);
        step("adc_c0",  2'd0, 4'd5, 32'h0, 32'h0, 32'h0, 4'b0100);
        step("br_zc",   2'd2, 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110);
        step("adc_c1",  2'd0, 4'd5, 32'h0, 32'h0, 32'h1, 4'b0000);

        step("cmn_wrap", 2'd0, 4'd11, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110);
        step("sbc_c1",   2'd0, 4'd6,  32'd5, 32'd3, 32'd2, 4'b0010);
        step("rsc_c1",   2'd0, 4'd7,  32'd3, 32'd5, 32'd2, 4'b0010);
        step("add_c0",   2'd0, 4'd4,  32'd1, 32'd1, 32'd2, 4'b0000);
        step("sbc_c0",   2'd0, 4'd6,  32'd5, 32'd3, 32'd1, 4'b0010);
        step("add_c0b",  2'd0, 4'd4,  32'd1, 32'd1, 32'd2, 4'b0000);
        step("rsc_c0",   2'd0, 4'd7,  32'd3, 32'd5, 32'd1, 4'b0010);

`ifdef ALU_MUL_EN
        step("mul", 2'd3, 4'd0, 32'd6, 32'd7, 32'd42, 4'b0000);
`else
        step("mul", 2'd3, 4'd0, 32'd6, 32'd7, 32'd0, 4'b0100);
`endif

        // Asynchronous reset away from any clock edge clears state at once.
        step("pre_rst", 2'd0, 4'd15, 32'h0, 32'h0, 32'hFFFF_FFFF, 4'b1000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_res", ALU_output, 32'd0);
        check_val("async_rst_flg", {28'd0, ALU_Flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Carry is cleared by reset, so ADC adds nothing extra.
        step("post_rst_adc", 2'd0, 4'd5, 32'd10, 32'd20, 32'd30, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
